inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Multi-cycle instruction fetch stage directly downstream of the program counter.
- Takes the current PC, issues a read on the instruction-memory bus and holds the returned instruction for the decode stage.
- Pulses pc_update when decode consumes the instruction, so the PC register advances exactly once per fetched instruction.
- Supports redirect flush, misalignment detection and a bus-response timeout.

Parameters:
- TIMEOUT, 255, max WAIT cycles without a response before a fetch fault (>=1)
- CNT_W, 8, timeout counter width; must hold TIMEOUT

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- pc  in  32  current PC-register value
- pc_update  out  1  PC-register write enable; high for one cycle per consumed instruction
- flush  in  1  redirect: discard held or in-flight fetch; top level loads the new PC in this cycle
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  read address
- imem_rsp_valid  in  1  read data valid
- imem_rsp_data  in  32  read data
- imem_rsp_err  in  1  bus error, qualified by imem_rsp_valid
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction
- inst  out  32  instruction word
- inst_pc  out  32  address the instruction was fetched from
- fetch_fault  out  1  inst is invalid (misaligned, bus error or timeout); qualified by inst_valid

Behaviour:
- States: IDLE, REQ, WAIT, FULL. Registers: inst, inst_pc, fault, drop flag, timeout counter.
- Reset (rst=1 at edge):
  - state=IDLE, inst=0, inst_pc=0, fault=0, drop=0, counter=0.
  - All handshake outputs 0 while in IDLE.
  - Reset mid-operation abandons any in-flight request; rsp_valid after reset is ignored until WAIT.
- IDLE: unconditionally -> REQ next cycle (one bubble after reset).
- REQ:
  - Misaligned address (pc[1:0]!=0): no bus request; next state FULL with inst=0, inst_pc=pc, fault=1.
  - Aligned address: imem_req_valid=1, imem_req_addr=pc (combinational; pc is stable in REQ).
  - On valid&&ready: latch inst_pc=pc, counter=0; -> WAIT. If flush is also high that cycle, also set drop=1.
  - Flush without a handshake: stay REQ; the address follows the new pc from the next cycle.
- WAIT:
  - imem_req_valid=0. Counter increments each cycle.
  - Response earliest one cycle after acceptance; imem_rsp_valid in any other state is ignored.
  - On imem_rsp_valid: if drop=1, clear drop and -> REQ. Otherwise latch inst=imem_rsp_data, fault=imem_rsp_err; -> FULL.
  - If counter reaches TIMEOUT-1 with no response: if drop=1, clear drop and -> REQ; else inst=0, fault=1, -> FULL.
  - Flush in WAIT sets drop=1 and stays in WAIT.
- FULL:
  - inst_valid = (state==FULL) && !flush, i.e. combinationally suppressed by flush.
  - Handshake inst_valid&&inst_ready: pc_update=1 that cycle (combinational); -> REQ. The PC register updates at the same edge, so REQ presents the new pc.
  - Flush in FULL (priority over inst_ready): no pc_update; -> REQ.
- inst, inst_pc and fetch_fault stay stable throughout FULL; they hold their last values elsewhere.
- pc_update is 0 in every state except a FULL-state handshake.
- Back-to-back throughput: minimum 3 cycles per instruction (REQ, WAIT, FULL) with a zero-wait memory.

Test Plan:
- Reset, then pc=0x80000000, memory ready=1 and responds 1 cycle after acceptance with 0x00000413, inst_ready=1 -> req at cycle 1, inst_valid at cycle 3 with inst=0x00000413, inst_pc=0x80000000, pc_update=1 for exactly that cycle; next req address 0x80000004.
- Decode stalls (inst_ready=0 for 5 cycles) -> inst_valid held high, inst/inst_pc stable, pc_update=0 throughout; single pc_update when ready rises.
- Flush in the same cycle as request acceptance, then response 0xDEADBEEF arrives -> response dropped, no inst_valid, new request issued to the redirected pc.
- Flush coincident with inst_valid&&inst_ready in FULL -> inst_valid low that cycle, pc_update=0, next state REQ.
- pc=0x80000002 -> no bus request; inst_valid with fetch_fault=1, inst=0, inst_pc=0x80000002. Response with imem_rsp_err=1 -> fetch_fault=1.
- Memory never responds, TIMEOUT=4 -> fault delivered 4 cycles after acceptance. Also assert rst while in WAIT -> IDLE next cycle with all outputs 0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Multi-cycle instruction fetch stage sitting between the PC register and decode.
// Issues one instruction-memory read per PC value, holds the returned word for
// decode, and pulses pc_update once per consumed instruction. It also handles
// redirect flushes, misaligned PCs and bus-response timeouts.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   pc                current PC-register value
//   pc_update         PC-register write enable, one cycle per consumed instruction
//   flush             redirect; discards held or in-flight fetch
//   imem_req_*        read request channel (valid/ready/addr)
//   imem_rsp_*        read response channel (valid/data/err)
//   inst_valid/ready  handshake to decode
//   inst, inst_pc     instruction word and the address it came from
//   fetch_fault       inst is invalid (misaligned, bus error or timeout)
module inst_fetch_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_update,
    input  logic        flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FULL = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      inst_pc_q, inst_pc_d;
    logic             fault_q, fault_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic misaligned;
    logic timeout_hit;
    logic discard;

    assign misaligned  = (pc[1:0] != 2'b00);
    assign timeout_hit = (cnt_q == CNT_LAST);
    // A flush arriving with the response still invalidates that response.
    assign discard     = drop_q | flush;

    assign imem_req_addr = pc;
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign fetch_fault   = fault_q;

    // Next-state and handshake logic
    always_comb begin
        state_d        = state_q;
        inst_d         = inst_q;
        inst_pc_d      = inst_pc_q;
        fault_d        = fault_q;
        drop_d         = drop_q;
        cnt_d          = cnt_q;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        pc_update      = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (misaligned) begin
                    // A flush means pc is about to change; re-evaluate next cycle.
                    if (!flush) begin
                        state_d   = S_FULL;
                        inst_d    = 32'd0;
                        inst_pc_d = pc;
                        fault_d   = 1'b1;
                    end
                end else begin
                    imem_req_valid = 1'b1;
                    if (imem_req_ready) begin
                        inst_pc_d = pc;
                        cnt_d     = '0;
                        drop_d    = flush;
                        state_d   = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (imem_rsp_valid || timeout_hit) begin
                    if (discard) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d  = imem_rsp_valid ? imem_rsp_data : 32'd0;
                        fault_d = imem_rsp_valid ? imem_rsp_err : 1'b1;
                        state_d = S_FULL;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end

            S_FULL: begin
                inst_valid = !flush;
                if (flush) begin
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_update = 1'b1;
                    state_d   = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and payload registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
            fault_q   <= 1'b0;
            drop_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a table of single fetches followed by
// hand-written sequences for stall, flush, timeout and mid-fetch reset.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_update;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int checks;
    int failures;

    inst_fetch_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_update      (pc_update),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
        int          delay;      // WAIT cycles with no response before it arrives
        logic [31:0] exp_inst;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_valid"},  32'(imem_req_valid), 32'd0);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_pc_update"},  32'(pc_update), 32'd0);
        chk({tag, "_inst"},       inst, 32'd0);
        chk({tag, "_inst_pc"},    inst_pc, 32'd0);
        chk({tag, "_fault"},      32'(fetch_fault), 32'd0);
    endtask

    // Entered at the start of a REQ cycle; leaves the DUT at the start of the next REQ.
    task automatic fetch(input vec_t v);
        pc             = v.pc;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b0;
        #1;
        if (v.pc[1:0] != 2'b00) begin
            chk("misaligned_no_req", 32'(imem_req_valid), 32'd0);
            cyc();
        end else begin
            chk("req_valid", 32'(imem_req_valid), 32'd1);
            chk("req_addr", imem_req_addr, v.pc);
            cyc();
            for (int d = 0; d < v.delay; d++) begin
                #1;
                chk("wait_no_inst", 32'(inst_valid), 32'd0);
                cyc();
            end
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = v.data;
            imem_rsp_err   = v.err;
            cyc();
            imem_rsp_valid = 1'b0;
            imem_rsp_err   = 1'b0;
        end
        inst_ready = 1'b1;
        #1;
        chk("inst_valid", 32'(inst_valid), 32'd1);
        chk("inst", inst, v.exp_inst);
        chk("inst_pc", inst_pc, v.pc);
        chk("fault", 32'(fetch_fault), 32'(v.exp_fault));
        chk("pc_update", 32'(pc_update), 32'd1);
        cyc();
        inst_ready = 1'b0;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        pc             = 32'h8000_0000;
        flush          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;

        vecs[0] = '{pc: 32'h8000_0000, data: 32'h0000_0413, err: 1'b0, delay: 0,
                    exp_inst: 32'h0000_0413, exp_fault: 1'b0};
        vecs[1] = '{pc: 32'h8000_0004, data: 32'h00a0_0093, err: 1'b0, delay: 2,
                    exp_inst: 32'h00a0_0093, exp_fault: 1'b0};
        vecs[2] = '{pc: 32'h8000_0008, data: 32'h1234_5678, err: 1'b1, delay: 0,
                    exp_inst: 32'h1234_5678, exp_fault: 1'b1};
        vecs[3] = '{pc: 32'h8000_0002, data: 32'h0, err: 1'b0, delay: 0,
                    exp_inst: 32'h0000_0000, exp_fault: 1'b1};
        // Response lands in the last allowed WAIT cycle: response beats timeout.
        vecs[4] = '{pc: 32'h0000_fffc, data: 32'hffff_ffff, err: 1'b0, delay: 3,
                    exp_inst: 32'hffff_ffff, exp_fault: 1'b0};

        // Reset: IDLE with all outputs zero, then REQ one cycle later.
        cyc();
        cyc();
        #1;
        chk_idle_outputs("reset");
        rst = 1'b0;
        cyc();

        foreach (vecs[i]) fetch(vecs[i]);

        // Decode stall for 5 cycles in FULL.
        pc             = 32'h8000_0010;
        imem_req_ready = 1'b1;
        cyc();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hcafe_0001;
        cyc();
        imem_rsp_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_no_update", 32'(pc_update), 32'd0);
            chk("stall_inst", inst, 32'hcafe_0001);
            chk("stall_inst_pc", inst_pc, 32'h8000_0010);
            cyc();
        end
        inst_ready = 1'b1;
        #1;
        chk("stall_release_update", 32'(pc_update), 32'd1);
        cyc();
        inst_ready = 1'b0;

        // Flush coincident with request acceptance: the response is dropped.
        pc    = 32'h8000_0020;
        flush = 1'b1;
        #1;
        chk("flushacc_req_valid", 32'(imem_req_valid), 32'd1);
        cyc();
        flush          = 1'b0;
        pc             = 32'h8000_0100;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hdead_beef;
        #1;
        chk("flushacc_wait_no_inst", 32'(inst_valid), 32'd0);
        cyc();
        imem_rsp_valid = 1'b0;
        #1;
        chk("flushacc_drop_no_inst", 32'(inst_valid), 32'd0);
        chk("flushacc_rereq_valid", 32'(imem_req_valid), 32'd1);
        chk("flushacc_rereq_addr", imem_req_addr, 32'h8000_0100);
        cyc();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        cyc();
        imem_rsp_valid = 1'b0;
        #1;
        chk("redirect_inst", inst, 32'h1111_1111);
        chk("redirect_inst_pc", inst_pc, 32'h8000_0100);

        // Flush in FULL beats inst_ready.
        flush      = 1'b1;
        inst_ready = 1'b1;
        #1;
        chk("flushfull_valid", 32'(inst_valid), 32'd0);
        chk("flushfull_no_update", 32'(pc_update), 32'd0);
        cyc();
        flush          = 1'b0;
        inst_ready     = 1'b0;
        pc             = 32'h8000_0200;
        imem_req_ready = 1'b0;
        #1;
        chk("flushfull_to_req", 32'(imem_req_valid), 32'd1);
        chk("flushfull_req_addr", imem_req_addr, 32'h8000_0200);

        // Flush in REQ without a handshake: stays in REQ, follows the new pc.
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        pc    = 32'h8000_0300;
        #1;
        chk("flushreq_valid", 32'(imem_req_valid), 32'd1);
        chk("flushreq_addr", imem_req_addr, 32'h8000_0300);
        imem_req_ready = 1'b1;
        cyc();

        // Timeout: no response for TIMEOUT=4 WAIT cycles, then a faulted FULL.
        for (int t = 0; t < 4; t++) begin
            #1;
            chk("timeout_wait_no_inst", 32'(inst_valid), 32'd0);
            chk("timeout_wait_no_req", 32'(imem_req_valid), 32'd0);
            cyc();
        end
        #1;
        chk("timeout_valid", 32'(inst_valid), 32'd1);
        chk("timeout_fault", 32'(fetch_fault), 32'd1);
        chk("timeout_inst", inst, 32'd0);
        chk("timeout_inst_pc", inst_pc, 32'h8000_0300);
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;

        // Reset while in WAIT: IDLE next cycle, stray response ignored.
        pc = 32'h8000_0400;
        cyc();
        rst = 1'b1;
        cyc();
        rst            = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h5555_aaaa;
        #1;
        chk_idle_outputs("rst_wait");
        cyc();
        #1;
        chk("rst_wait_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rst_wait_inst_valid", 32'(inst_valid), 32'd0);
        imem_rsp_valid = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
